// File: rtl/regwrite_seq.sv
// regwrite_seq: turns the framed word stream from the serial front end into
// register-file write cycles.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   data_in/data_ready  received word and its one-cycle valid strobe
//   new_transfer      one-cycle strobe, start of a transfer
//   transfer_done     one-cycle strobe, end of a transfer
//   write_addr/data   pending register write
//   write_enable      write pending; held until write_ready
//   write_ready       register file accepts the pending write this cycle
//   write_done        one-cycle pulse once a finished transfer has drained
//   write_count       writes accepted in the current transfer (saturating)
//   busy              sequencer active or a write pending
//   overrun_err       sticky: word arrived while the write stage was full
//   range_err         sticky: bad header address or overflow with no wrap
module regwrite_seq #(
  parameter int width     = 16,
  parameter int num_reg   = 4,
  parameter int addr_hdr  = 0,
  parameter int wrap_mode = 1,
  parameter int cnt_width = 8,
  localparam int addr_width = (num_reg > 1) ? $clog2(num_reg) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [width-1:0]      data_in,
  input  logic                  data_ready,
  input  logic                  new_transfer,
  input  logic                  transfer_done,
  output logic [addr_width-1:0] write_addr,
  output logic [width-1:0]      write_data,
  output logic                  write_enable,
  input  logic                  write_ready,
  output logic                  write_done,
  output logic [cnt_width-1:0]  write_count,
  output logic                  busy,
  output logic                  overrun_err,
  output logic                  range_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_SKIP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(num_reg - 1);
  localparam logic [width-1:0]      NUM_REG_W = width'(num_reg);

  logic [2:0]            state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [addr_width-1:0] waddr_q, waddr_d;
  logic [width-1:0]      wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic [cnt_width-1:0]  cnt_q, cnt_d;
  logic                  ovr_q, ovr_d;
  logic                  rng_q, rng_d;

  // new_transfer is folded in first so a word arriving in the same cycle is
  // treated as the first word of the new transfer.
  logic [2:0]            st_eff;
  logic [addr_width-1:0] addr_eff;

  always_comb begin
    st_eff   = new_transfer ? ((addr_hdr != 0) ? S_HDR : S_DATA) : state_q;
    addr_eff = new_transfer ? '0 : addr_q;

    state_d = st_eff;
    addr_d  = addr_eff;
    ovr_d   = new_transfer ? 1'b0 : ovr_q;
    rng_d   = new_transfer ? 1'b0 : rng_q;
    // A pending write survives new_transfer; it just retires on write_ready.
    we_d    = we_q & ~write_ready;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;

    // The clear on new_transfer wins: a write left over from the previous
    // transfer is not counted against the new one.
    if (new_transfer)                    cnt_d = '0;
    else if (we_q && write_ready && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    else                                 cnt_d = cnt_q;

    case (st_eff)
      S_HDR: begin
        if (data_ready) begin
          if (data_in < NUM_REG_W) begin
            addr_d  = data_in[addr_width-1:0];
            state_d = S_DATA;
          end else begin
            rng_d   = 1'b1;
            state_d = S_SKIP;
          end
        end
      end
      S_DATA: begin
        if (data_ready) begin
          if (!we_q || write_ready) begin
            we_d    = 1'b1;
            waddr_d = addr_eff;
            wdata_d = data_in;
            if (addr_eff == LAST_ADDR) begin
              addr_d = '0;
              if (wrap_mode == 0) state_d = S_SKIP;
            end else begin
              addr_d = addr_eff + 1'b1;
            end
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      S_SKIP: begin
        // Without wrap, anything landing here ran off the register space.
        if (data_ready && wrap_mode == 0) rng_d = 1'b1;
      end
      S_DRAIN: begin
        if (!we_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // Any word in the same cycle has been handled above.
    if (transfer_done && (st_eff == S_HDR || st_eff == S_DATA || st_eff == S_SKIP))
      state_d = S_DRAIN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      rng_q   <= rng_d;
    end
  end

  assign write_addr   = waddr_q;
  assign write_data   = wdata_q;
  assign write_enable = we_q;
  assign write_done   = done_q;
  assign write_count  = cnt_q;
  assign overrun_err  = ovr_q;
  assign range_err    = rng_q;
  assign busy         = (state_q != S_IDLE) | we_q;

endmodule

// File: tb/tb_regwrite_seq.sv
// Bench for regwrite_seq: three instances (plain/wrap, header/wrap,
// plain/stop) share one stimulus; sel picks which one the scoreboard watches.
module tb_regwrite_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_ready = 1'b0, new_transfer = 1'b0, transfer_done = 1'b0;
  logic        write_ready = 1'b1;

  logic [2:0]       we, dn, bz, ov, rg;
  logic [2:0][1:0]  wa;
  logic [2:0][15:0] wd;
  logic [2:0][7:0]  wc;

  int sel = 0;
  logic        m_we, m_dn, m_bz, m_ov, m_rg;
  logic [1:0]  m_wa;
  logic [15:0] m_wd;
  logic [7:0]  m_wc;

  typedef struct { logic [1:0] a; logic [15:0] d; } wr_t;
  wr_t sb[$];

  int total = 0, passed = 0, fails = 0, done_cnt = 0;

  always #5 clk = ~clk;

  regwrite_seq #(.width(16), .num_reg(4), .addr_hdr(0), .wrap_mode(1), .cnt_width(8)) u_a (
    .clk(clk), .rst(rst), .data_in(data_in), .data_ready(data_ready),
    .new_transfer(new_transfer), .transfer_done(transfer_done),
    .write_addr(wa[0]), .write_data(wd[0]), .write_enable(we[0]), .write_ready(write_ready),
    .write_done(dn[0]), .write_count(wc[0]), .busy(bz[0]), .overrun_err(ov[0]), .range_err(rg[0]));

  regwrite_seq #(.width(16), .num_reg(4), .addr_hdr(1), .wrap_mode(1), .cnt_width(8)) u_h (
    .clk(clk), .rst(rst), .data_in(data_in), .data_ready(data_ready),
    .new_transfer(new_transfer), .transfer_done(transfer_done),
    .write_addr(wa[1]), .write_data(wd[1]), .write_enable(we[1]), .write_ready(write_ready),
    .write_done(dn[1]), .write_count(wc[1]), .busy(bz[1]), .overrun_err(ov[1]), .range_err(rg[1]));

  regwrite_seq #(.width(16), .num_reg(4), .addr_hdr(0), .wrap_mode(0), .cnt_width(8)) u_s (
    .clk(clk), .rst(rst), .data_in(data_in), .data_ready(data_ready),
    .new_transfer(new_transfer), .transfer_done(transfer_done),
    .write_addr(wa[2]), .write_data(wd[2]), .write_enable(we[2]), .write_ready(write_ready),
    .write_done(dn[2]), .write_count(wc[2]), .busy(bz[2]), .overrun_err(ov[2]), .range_err(rg[2]));

  always_comb begin
    m_we = we[sel]; m_dn = dn[sel]; m_bz = bz[sel]; m_ov = ov[sel]; m_rg = rg[sel];
    m_wa = wa[sel]; m_wd = wd[sel]; m_wc = wc[sel];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && m_we && write_ready) begin
      chk("write_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(m_wa), 32'(e.a));
        chk("wr_data", 32'(m_wd), 32'(e.d));
      end
    end
    if (rst && m_dn) done_cnt++;
  end

  task automatic cyc(input logic nt, input logic dr, input logic td, input logic [15:0] d);
    new_transfer = nt; data_ready = dr; transfer_done = td; data_in = d;
    @(posedge clk); #1;
    new_transfer = 1'b0; data_ready = 1'b0; transfer_done = 1'b0;
  endtask

  task automatic push(input logic [1:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  task automatic do_reset(input int s);
    rst = 1'b0; write_ready = 1'b1; sb.delete();
    new_transfer = 1'b0; data_ready = 1'b0; transfer_done = 1'b0;
    sel = s;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    done_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // ---- plain mode, wrap, always ready ----
    do_reset(0);
    chk("rst_we", 32'(m_we), 0);
    chk("rst_busy", 32'(m_bz), 0);
    chk("rst_count", 32'(m_wc), 0);
    chk("rst_errs", 32'({m_ov, m_rg, m_dn}), 0);
    chk("rst_addr_data", 32'({m_wa, m_wd}), 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      push(2'(i % 4), 16'(16'hA0 + i));
      cyc(0, 1, 0, 16'(16'hA0 + i));
      chk("a_latency", 32'(m_we), 1);
    end
    cyc(0, 0, 1, 0);
    idle(3);
    chk("a_count", 32'(m_wc), 6);
    chk("a_done", done_cnt, 1);
    chk("a_errs", 32'({m_ov, m_rg}), 0);
    chk("a_sb_empty", sb.size(), 0);
    chk("a_busy", 32'(m_bz), 0);

    // ---- header mode ----
    do_reset(1);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 16'd2);
    chk("h_hdr_nowrite", 32'(m_we), 0);
    push(2, 16'h11); cyc(0, 1, 0, 16'h11);
    push(3, 16'h22); cyc(0, 1, 0, 16'h22);
    push(0, 16'h33); cyc(0, 1, 0, 16'h33);
    cyc(0, 0, 1, 0);
    idle(3);
    chk("h_count", 32'(m_wc), 3);
    chk("h_done", done_cnt, 1);
    chk("h_range", 32'(m_rg), 0);
    done_cnt = 0;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 16'd7);
    chk("h7_range", 32'(m_rg), 1);
    cyc(0, 1, 0, 16'h44);
    chk("h7_nowrite", 32'(m_we), 0);
    cyc(0, 0, 1, 0);
    idle(3);
    chk("h7_done", done_cnt, 1);
    chk("h7_count", 32'(m_wc), 0);

    // ---- stop mode ----
    do_reset(2);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      push(2'(i), 16'(16'h50 + i));
      cyc(0, 1, 0, 16'(16'h50 + i));
    end
    chk("s_range_before", 32'(m_rg), 0);
    cyc(0, 1, 0, 16'h54);
    chk("s_range_after", 32'(m_rg), 1);
    cyc(0, 0, 1, 0);
    idle(3);
    chk("s_count", 32'(m_wc), 4);
    chk("s_done", done_cnt, 1);
    chk("s_overrun", 32'(m_ov), 0);
    chk("s_sb_empty", sb.size(), 0);

    // ---- backpressure ----
    do_reset(0);
    cyc(1, 0, 0, 0);
    push(0, 16'hB1);
    cyc(0, 1, 0, 16'hB1);
    write_ready = 1'b0;
    cyc(0, 1, 0, 16'hB2);
    chk("b_overrun", 32'(m_ov), 1);
    chk("b_hold_we", 32'(m_we), 1);
    chk("b_hold_addr", 32'(m_wa), 0);
    chk("b_hold_data", 32'(m_wd), 32'h00B1);
    cyc(0, 0, 1, 0);
    chk("b_busy", 32'(m_bz), 1);
    chk("b_no_done_stall", 32'(m_dn), 0);
    idle(1);
    chk("b_hold_data2", 32'(m_wd), 32'h00B1);
    write_ready = 1'b1;
    idle(1);
    chk("b_no_done_accept", 32'(m_dn), 0);
    chk("b_we_clear", 32'(m_we), 0);
    idle(1);
    chk("b_done_pulse", 32'(m_dn), 1);
    idle(1);
    chk("b_done_once", 32'(m_dn), 0);
    chk("b_done_cnt", done_cnt, 1);
    chk("b_count", 32'(m_wc), 1);
    chk("b_sb_empty", sb.size(), 0);

    // ---- simultaneous strobes ----
    do_reset(0);
    cyc(1, 0, 0, 0);
    push(0, 16'hC0);
    write_ready = 1'b0;
    cyc(0, 1, 0, 16'hC0);
    cyc(0, 1, 0, 16'hC1);
    chk("c_overrun_set", 32'(m_ov), 1);
    write_ready = 1'b1;
    idle(1);
    done_cnt = 0;
    push(0, 16'hD0);
    cyc(1, 1, 0, 16'hD0);
    chk("c_overrun_clr", 32'(m_ov), 0);
    chk("c_first_word", 32'(m_we), 1);
    push(1, 16'hD1);
    cyc(0, 1, 1, 16'hD1);
    chk("c_last_word", 32'(m_we), 1);
    idle(3);
    chk("c_done", done_cnt, 1);
    chk("c_count", 32'(m_wc), 2);
    chk("c_sb_empty", sb.size(), 0);

    // ---- async reset mid-transfer ----
    do_reset(0);
    cyc(1, 0, 0, 0);
    write_ready = 1'b0;
    push(0, 16'hE0);
    cyc(0, 1, 0, 16'hE0);
    chk("r_pending", 32'(m_we), 1);
    #2 rst = 1'b0;
    #1;
    chk("r_async_we", 32'(m_we), 0);
    chk("r_async_addr_data", 32'({m_wa, m_wd}), 0);
    chk("r_async_busy_flags", 32'({m_bz, m_ov, m_rg, m_dn}), 0);
    chk("r_async_count", 32'(m_wc), 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1; write_ready = 1'b1;
    idle(1);
    chk("r_no_stale", 32'(m_we), 0);
    cyc(1, 0, 0, 0);
    push(0, 16'hF0);
    cyc(0, 1, 0, 16'hF0);
    chk("r_new_write", 32'(m_we), 1);
    cyc(0, 0, 1, 0);
    idle(3);
    chk("r_count", 32'(m_wc), 1);
    chk("r_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
